// File: rtl/half_adder.sv
// half_adder: WIDTH independent half-adder lanes. Each lane has a
// combinational Sum/Carry pair and a registered copy tagged with valid_q.
// Lanes never interact, so there is no carry chain between bits.
module half_adder #(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             en,
  output logic [WIDTH-1:0] Sum,
  output logic [WIDTH-1:0] Carry,
  output logic [WIDTH-1:0] sum_q,
  output logic [WIDTH-1:0] carry_q,
  output logic             valid_q
);

  // Bitwise operators keep any X on one lane confined to that lane's outputs.
  assign Sum   = A ^ B;
  assign Carry = A & B;

  // Capture the combinational result on enabled edges; valid_q marks a fresh
  // capture and drops on any edge without en, while the data simply holds.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sum_q   <= '0;
      carry_q <= '0;
      valid_q <= 1'b0;
    end else if (en) begin
      sum_q   <= Sum;
      carry_q <= Carry;
      valid_q <= 1'b1;
    end else begin
      valid_q <= 1'b0;
    end
  end

endmodule

// File: tb/tb_half_adder.sv
// tb_half_adder: directed table of combinational vectors plus hand-written
// sequences for capture, hold, asynchronous reset and reset release, and an
// exhaustive sweep of every A/B pair on the low four lanes.
module tb_half_adder;

  localparam int W = 8;

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] expSum;
    logic [W-1:0] expCarry;
  } vector_t;

  logic         clk = 1'b0;
  logic         rst_n;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         en;
  logic [W-1:0] sum;
  logic [W-1:0] carry;
  logic [W-1:0] sumQ;
  logic [W-1:0] carryQ;
  logic         validQ;

  int checks   = 0;
  int failures = 0;

  vector_t vectors[8];

  half_adder #(.WIDTH(W)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .A       (a),
    .B       (b),
    .en      (en),
    .Sum     (sum),
    .Carry   (carry),
    .sum_q   (sumQ),
    .carry_q (carryQ),
    .valid_q (validQ)
  );

  // Free-running clock, rising edges at 5, 15, 25, ...
  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [63:0] actual,
                             input logic [63:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
    end
  endtask

  // Inputs always change on the falling edge, away from the capture edge.
  task automatic applyStimulus(input logic [W-1:0] na, input logic [W-1:0] nb,
                               input logic nen);
    @(negedge clk);
    a  = na;
    b  = nb;
    en = nen;
  endtask

  // Reference: each lane is a 1-bit + 1-bit arithmetic add giving {carry,sum}.
  task automatic laneModel(input logic [W-1:0] ma, input logic [W-1:0] mb,
                           output logic [W-1:0] ms, output logic [W-1:0] mc);
    logic [1:0] t;
    for (int i = 0; i < W; i++) begin
      t     = {1'b0, ma[i]} + {1'b0, mb[i]};
      ms[i] = t[0];
      mc[i] = t[1];
    end
  endtask

  initial begin
    logic [W-1:0] expS;
    logic [W-1:0] expC;
    logic [3:0]   hiA;
    logic [3:0]   hiB;

    vectors[0] = '{8'h00, 8'h00, 8'h00, 8'h00};
    vectors[1] = '{8'h00, 8'h01, 8'h01, 8'h00};
    vectors[2] = '{8'h01, 8'h00, 8'h01, 8'h00};
    vectors[3] = '{8'h01, 8'h01, 8'h00, 8'h01};
    vectors[4] = '{8'hF0, 8'h3C, 8'hCC, 8'h30};
    vectors[5] = '{8'hFF, 8'hFF, 8'h00, 8'hFF};
    vectors[6] = '{8'hFF, 8'h00, 8'hFF, 8'h00};
    vectors[7] = '{8'hAA, 8'h55, 8'hFF, 8'h00};

    rst_n = 1'b0;
    a     = '0;
    b     = '0;
    en    = 1'b0;

    // Reset state, checked between edges.
    #12;
    checkOutput("reset sum_q", sumQ, 0);
    checkOutput("reset carry_q", carryQ, 0);
    checkOutput("reset valid_q", validQ, 0);

    // Combinational path works while held in reset.
    a = 8'hA5;
    b = 8'h0F;
    #1;
    checkOutput("reset-comb Sum", sum, 8'hAA);
    checkOutput("reset-comb Carry", carry, 8'h05);

    @(negedge clk);
    rst_n = 1'b1;
    a     = '0;
    b     = '0;

    // Table: en=0, registered outputs must keep their reset values.
    for (int i = 0; i < 8; i++) begin
      a = vectors[i].a;
      b = vectors[i].b;
      #10;
      checkOutput($sformatf("vec%0d Sum", i), sum, vectors[i].expSum);
      checkOutput($sformatf("vec%0d Carry", i), carry, vectors[i].expCarry);
      checkOutput($sformatf("vec%0d sum_q hold", i), sumQ, 0);
      checkOutput($sformatf("vec%0d carry_q hold", i), carryQ, 0);
      checkOutput($sformatf("vec%0d valid_q", i), validQ, 0);
    end

    // Capture 1+1 on lane 0, then hold with en=0.
    applyStimulus(8'h01, 8'h01, 1'b1);
    @(posedge clk); #1;
    checkOutput("cap11 sum_q", sumQ, 8'h00);
    checkOutput("cap11 carry_q", carryQ, 8'h01);
    checkOutput("cap11 valid_q", validQ, 1);
    applyStimulus(8'h00, 8'h01, 1'b0);
    @(posedge clk); #1;
    checkOutput("hold sum_q", sumQ, 8'h00);
    checkOutput("hold carry_q", carryQ, 8'h01);
    checkOutput("hold valid_q", validQ, 0);
    checkOutput("hold Sum", sum, 8'h01);

    // Eight-lane capture, no inter-lane carry.
    applyStimulus(8'hF0, 8'h3C, 1'b1);
    @(posedge clk); #1;
    checkOutput("cap8 sum_q", sumQ, 8'hCC);
    checkOutput("cap8 carry_q", carryQ, 8'h30);
    checkOutput("cap8 valid_q", validQ, 1);

    // Asynchronous reset between edges discards the captured result.
    applyStimulus(8'h01, 8'h00, 1'b1);
    @(posedge clk); #1;
    checkOutput("pre-reset sum_q", sumQ, 8'h01);
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("async sum_q", sumQ, 0);
    checkOutput("async carry_q", carryQ, 0);
    checkOutput("async valid_q", validQ, 0);
    checkOutput("async Sum", sum, 8'h01);
    a = 8'h03;
    b = 8'h01;
    #1;
    checkOutput("in-reset Sum", sum, 8'h02);
    checkOutput("in-reset Carry", carry, 8'h01);
    @(posedge clk); #1;
    checkOutput("in-reset edge sum_q", sumQ, 0);
    checkOutput("in-reset edge valid_q", validQ, 0);

    // Release with en=1: first edge captures normally.
    @(negedge clk);
    a     = 8'h00;
    b     = 8'h01;
    en    = 1'b1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    checkOutput("release sum_q", sumQ, 8'h01);
    checkOutput("release carry_q", carryQ, 8'h00);
    checkOutput("release valid_q", validQ, 1);

    // Every A/B pair on the low four lanes, random values on the upper lanes.
    for (int ia = 0; ia < 16; ia++) begin
      for (int ib = 0; ib < 16; ib++) begin
        hiA = 4'($urandom_range(0, 15));
        hiB = 4'($urandom_range(0, 15));
        applyStimulus({hiA, 4'(ia)}, {hiB, 4'(ib)}, 1'b1);
        laneModel(a, b, expS, expC);
        #1;
        checkOutput($sformatf("sweep %0h+%0h Sum", a, b), sum, expS);
        checkOutput($sformatf("sweep %0h+%0h Carry", a, b), carry, expC);
        @(posedge clk); #1;
        checkOutput($sformatf("sweep %0h+%0h sum_q", a, b), sumQ, expS);
        checkOutput($sformatf("sweep %0h+%0h carry_q", a, b), carryQ, expC);
      end
    end
    checkOutput("sweep valid_q", validQ, 1);

    // Dropping en after the sweep clears valid and holds the last data.
    applyStimulus(8'h00, 8'h00, 1'b0);
    @(posedge clk); #1;
    checkOutput("final valid_q", validQ, 0);
    checkOutput("final sum_q", sumQ, expS);
    checkOutput("final carry_q", carryQ, expC);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
